// File: rtl/pix28_axi_pkg.sv
// Shared types and response codes for the pix28 AXI4-Lite register banks.
package pix28_axi_pkg;

   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4lite_strb_merge.sv
// Byte-lane merge of write data into an existing register value under a strobe mask.
module axi4lite_strb_merge #(
   parameter int unsigned DW = 64
) (
   input  logic [DW-1:0]   old_data,
   input  logic [DW-1:0]   wdata,
   input  logic [DW/8-1:0] wstrb,
   output logic [DW-1:0]   new_data
);

   always_comb begin
      new_data = old_data;
      for (int unsigned b = 0; b < DW/8; b++) begin
         if (wstrb[b]) new_data[b*8 +: 8] = wdata[b*8 +: 8];
      end
   end

endmodule

// File: rtl/axi4lite_regbank_pix28.sv
// AXI4-Lite slave register bank: N_WR software-written control registers with update
// pulses and N_RD firmware status registers with read-acknowledge pulses.
module axi4lite_regbank_pix28
   import pix28_axi_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 64,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 11,
   parameter int unsigned N_WR = 4,
   parameter int unsigned N_RD = 4,
   parameter logic [C_S_AXI_DATA_WIDTH-1:0] WR_RESET_VAL = '0
) (
   input  logic                               S_AXI_ACLK,
   input  logic                               S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
   input  logic [2:0]                         S_AXI_AWPROT,
   input  logic                               S_AXI_AWVALID,
   output logic                               S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
   input  logic                               S_AXI_WVALID,
   output logic                               S_AXI_WREADY,
   output logic [1:0]                         S_AXI_BRESP,
   output logic                               S_AXI_BVALID,
   input  logic                               S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
   input  logic [2:0]                         S_AXI_ARPROT,
   input  logic                               S_AXI_ARVALID,
   output logic                               S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
   output logic [1:0]                         S_AXI_RRESP,
   output logic                               S_AXI_RVALID,
   input  logic                               S_AXI_RREADY,
   output logic [N_WR*C_S_AXI_DATA_WIDTH-1:0] sw_write_regs,
   output logic [N_WR-1:0]                    sw_write_pulse,
   input  logic [N_RD*C_S_AXI_DATA_WIDTH-1:0] sw_read_regs,
   output logic [N_RD-1:0]                    sw_read_pulse
);

   localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned OFF_W = $clog2(SW);
   localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - OFF_W;

   wr_state_t        wr_state_q, wr_state_d;
   rd_state_t        rd_state_q, rd_state_d;
   logic             aw_held_q, aw_held_d;
   logic             w_held_q, w_held_d;
   logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
   logic [DW-1:0]    w_data_q, w_data_d;
   logic [SW-1:0]    w_strb_q, w_strb_d;
   logic [DW-1:0]    ctrl_q [N_WR];
   logic [DW-1:0]    ctrl_d [N_WR];
   logic [N_WR-1:0]  wr_pulse_q, wr_pulse_d;
   logic [1:0]       bresp_q, bresp_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic [1:0]       rresp_q, rresp_d;
   logic [N_RD-1:0]  rd_pulse_q, rd_pulse_d;

   logic             aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0] ar_idx;
   logic [DW-1:0]    sel_old, merged;
   logic             unused_inputs;

   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                            S_AXI_AWADDR[OFF_W-1:0], S_AXI_ARADDR[OFF_W-1:0]};

   assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:OFF_W];
   assign commit = (wr_state_q == W_WAIT) && aw_held_q && w_held_q;

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         wr_state_q <= W_IDLE;
         rd_state_q <= R_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_idx_q   <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         for (int unsigned i = 0; i < N_WR; i++) ctrl_q[i] <= WR_RESET_VAL;
         wr_pulse_q <= '0;
         bresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         rd_pulse_q <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         aw_idx_q   <= aw_idx_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         for (int unsigned i = 0; i < N_WR; i++) ctrl_q[i] <= ctrl_d[i];
         wr_pulse_q <= wr_pulse_d;
         bresp_q    <= bresp_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rd_pulse_q <= rd_pulse_d;
      end
   end

   always_comb begin
      wr_state_d = wr_state_q;
      case (wr_state_q)
         W_IDLE:  if (aw_hs || w_hs) wr_state_d = W_WAIT;
         W_WAIT:  if (commit)        wr_state_d = W_RESP;
         W_RESP:  if (S_AXI_BREADY)  wr_state_d = W_IDLE;
         default:                    wr_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         R_IDLE:  if (ar_hs)         rd_state_d = R_DATA;
         R_DATA:  if (S_AXI_RREADY)  rd_state_d = R_IDLE;
         default:                    rd_state_d = R_IDLE;
      endcase
   end

   // Each address/data channel stays ready until its half of the pair is held.
   always_comb begin
      S_AXI_AWREADY = !S_AXI_ARESET && (wr_state_q != W_RESP) && !aw_held_q;
      S_AXI_WREADY  = !S_AXI_ARESET && (wr_state_q != W_RESP) && !w_held_q;
      S_AXI_BVALID  = (wr_state_q == W_RESP);
      S_AXI_BRESP   = bresp_q;
      S_AXI_ARREADY = !S_AXI_ARESET && (rd_state_q == R_IDLE);
      S_AXI_RVALID  = (rd_state_q == R_DATA);
      S_AXI_RDATA   = rdata_q;
      S_AXI_RRESP   = rresp_q;
      sw_write_pulse = wr_pulse_q;
      sw_read_pulse  = rd_pulse_q;
      sw_write_regs  = '0;
      for (int unsigned i = 0; i < N_WR; i++) sw_write_regs[i*DW +: DW] = ctrl_q[i];
   end

   always_comb begin
      sel_old = '0;
      for (int unsigned i = 0; i < N_WR; i++) begin
         if (aw_idx_q == IDX_W'(i)) sel_old = ctrl_q[i];
      end
   end

   axi4lite_strb_merge #(
      .DW (DW)
   ) u_strb_merge (
      .old_data (sel_old),
      .wdata    (w_data_q),
      .wstrb    (w_strb_q),
      .new_data (merged)
   );

   always_comb begin
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_idx_d   = aw_idx_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      ctrl_d     = ctrl_q;
      wr_pulse_d = '0;
      bresp_d    = bresp_q;
      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:OFF_W];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bresp_d   = (aw_idx_q < IDX_W'(N_WR)) ? RESP_OKAY : RESP_SLVERR;
         for (int unsigned i = 0; i < N_WR; i++) begin
            if (aw_idx_q == IDX_W'(i)) begin
               ctrl_d[i]     = merged;
               wr_pulse_d[i] = 1'b1;
            end
         end
      end
   end

   // Control values come from the flops, so a read racing a commit sees the old value.
   always_comb begin
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rd_pulse_d = '0;
      if (ar_hs) begin
         rdata_d = '0;
         rresp_d = RESP_SLVERR;
         for (int unsigned i = 0; i < N_WR; i++) begin
            if (ar_idx == IDX_W'(i)) begin
               rdata_d = ctrl_q[i];
               rresp_d = RESP_OKAY;
            end
         end
         for (int unsigned i = 0; i < N_RD; i++) begin
            if (ar_idx == IDX_W'(N_WR + i)) begin
               rdata_d       = sw_read_regs[i*DW +: DW];
               rresp_d       = RESP_OKAY;
               rd_pulse_d[i] = 1'b1;
            end
         end
      end
   end

endmodule
